cache_ctrl_top: RTL and testbench

- Dual-processor cache controller top level. Two independent "processor" channels each own a program buffer and a private direct-mapped cache, and share one 256x8 main memory.
- Each channel's program is serially loaded through its 8-bit input port.
- On start, each channel replays its operations against its cache and reports a hit flag and the read data.

---
 rtl/cache_ctrl_top.sv | 190 +++++++++++++++++++
 tb/tb_cache_ctrl_top.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_top.sv
// Dual-channel cache controller: two program-driven direct-mapped caches
// over one shared 256x8 memory. Define CACHE_SNOOP_EN for write snooping.
module cache_ctrl_top #(
  parameter int NUM_OPS = 2,
  parameter int LINES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       store1,
  input  logic       store2,
  input  logic [7:0] input_data_1,
  input  logic [7:0] input_data_2,
  output logic       hit_1,
  output logic       hit_2,
  output logic [7:0] read_data_1,
  output logic [7:0] read_data_2
);
  localparam int SLOTS = 4 * NUM_OPS;
  localparam int PW = $clog2(SLOTS);
  localparam int CW = $clog2(SLOTS + 1);
  localparam int OW = $clog2(NUM_OPS + 1);
  localparam int IW = $clog2(LINES);
  localparam int TW = 8 - IW;
`ifdef CACHE_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, RUN, LOOKUP, FILL, WRITE, DONE
  } st_t;

  st_t st [2];
  st_t st_n [2];

  logic [7:0]    mem [256];
  logic [7:0]    prog [2][SLOTS];
  logic [CW-1:0] cnt [2];
  logic [OW-1:0] opi [2];
  logic          vld [2][LINES];
  logic [TW-1:0] tag [2][LINES];
  logic [7:0]    dat [2][LINES];
  logic          hit [2];
  logic [7:0]    rdat [2];

  logic          store [2];
  logic [7:0]    din [2];
  logic [OW-1:0] sel [2];
  logic          op_wr [2];
  logic [7:0]    raddr [2];
  logic [7:0]    waddr [2];
  logic [7:0]    wdata [2];
  logic [7:0]    laddr [2];
  logic          lk_hit [2];
  logic          mem_we [2];
  logic [TW-1:0] snp_tag [2];
  logic          snp [2];

  function automatic logic [PW-1:0] slot(
    input int k, input logic [OW-1:0] i
  );
    return PW'(k * NUM_OPS) + PW'(i);
  endfunction

  function automatic logic [IW-1:0] lidx(input logic [7:0] a);
    return a[IW-1:0];
  endfunction

  function automatic logic [TW-1:0] ltag(input logic [7:0] a);
    return a[7:IW];
  endfunction

  assign store[0] = store1;
  assign store[1] = store2;
  assign din[0]   = input_data_1;
  assign din[1]   = input_data_2;

  assign hit_1       = hit[0];
  assign hit_2       = hit[1];
  assign read_data_1 = rdat[0];
  assign read_data_2 = rdat[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[0] <= IDLE;
      st[1] <= IDLE;
    end else begin
      st[0] <= st_n[0];
      st[1] <= st_n[1];
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      st_n[c] = st[c];
      unique case (st[c])
        IDLE:
          if (start && !store[c]) st_n[c] = RUN;
        RUN:
          st_n[c] = (opi[c] == OW'(NUM_OPS)) ? DONE : LOOKUP;
        LOOKUP:
          st_n[c] = op_wr[c] ? WRITE
                  : (lk_hit[c] ? RUN : FILL);
        FILL:
          st_n[c] = RUN;
        WRITE:
          if (mem_we[c]) st_n[c] = RUN;
        DONE:
          st_n[c] = DONE;
        default:
          st_n[c] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      sel[c] = (opi[c] < OW'(NUM_OPS)) ? opi[c] : '0;
      op_wr[c] = prog[c][slot(0, sel[c])][0];
      raddr[c] = prog[c][slot(1, sel[c])];
      waddr[c] = prog[c][slot(2, sel[c])];
      wdata[c] = prog[c][slot(3, sel[c])];
      laddr[c] = op_wr[c] ? waddr[c] : raddr[c];
      lk_hit[c] = vld[c][lidx(laddr[c])]
        && (tag[c][lidx(laddr[c])] == ltag(laddr[c]));
    end
    // channel 1 owns the single memory write port
    mem_we[0] = (st[0] == WRITE);
    mem_we[1] = (st[1] == WRITE) && (st[0] != WRITE);
    for (int c = 0; c < 2; c++) begin
      snp_tag[c] = (st[c] == FILL
        && lidx(raddr[c]) == lidx(waddr[1-c]))
        ? ltag(raddr[c])
        : tag[c][lidx(waddr[1-c])];
      snp[c] = SNOOP && mem_we[1-c]
        && (snp_tag[c] == ltag(waddr[1-c]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
      for (int c = 0; c < 2; c++) begin
        cnt[c]  <= '0;
        opi[c]  <= '0;
        hit[c]  <= 1'b0;
        rdat[c] <= '0;
        for (int s = 0; s < SLOTS; s++) prog[c][s] <= '0;
        for (int l = 0; l < LINES; l++) begin
          vld[c][l] <= 1'b0;
          tag[c][l] <= '0;
          dat[c][l] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        hit[c] <= (st[c] == LOOKUP) && lk_hit[c];
        if (st[c] == IDLE && store[c]
            && cnt[c] != CW'(SLOTS)) begin
          prog[c][PW'(cnt[c])] <= din[c];
          cnt[c] <= cnt[c] + CW'(1);
        end
        if (st[c] == LOOKUP && !op_wr[c] && lk_hit[c]) begin
          rdat[c] <= dat[c][lidx(raddr[c])];
          opi[c]  <= opi[c] + OW'(1);
        end
        if (st[c] == FILL) begin
          rdat[c] <= mem[raddr[c]];
          vld[c][lidx(raddr[c])] <= 1'b1;
          tag[c][lidx(raddr[c])] <= ltag(raddr[c]);
          dat[c][lidx(raddr[c])] <= mem[raddr[c]];
          opi[c] <= opi[c] + OW'(1);
        end
        if (mem_we[c]) begin
          mem[waddr[c]] <= wdata[c];
          vld[c][lidx(waddr[c])] <= 1'b1;
          tag[c][lidx(waddr[c])] <= ltag(waddr[c]);
          dat[c][lidx(waddr[c])] <= wdata[c];
          opi[c] <= opi[c] + OW'(1);
        end
      end
      // invalidation overrides a same-edge fill of that line
      for (int c = 0; c < 2; c++)
        if (snp[c]) vld[c][lidx(waddr[1-c])] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_top.sv
// Bench for cache_ctrl_top: edge-level reference model of the two
// channels plus directed programs with hand-derived checkpoints.
module tb_cache_ctrl_top;
  localparam int N  = 2;
  localparam int SL = 4 * N;
`ifdef CACHE_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, store1, store2;
  logic [7:0] input_data_1, input_data_2;
  logic       hit_1, hit_2;
  logic [7:0] read_data_1, read_data_2;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 1'b0;
  logic [7:0] w1 [10];
  logic [7:0] w2 [10];

  cache_ctrl_top #(.NUM_OPS(N), .LINES(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .store1(store1), .store2(store2),
    .input_data_1(input_data_1),
    .input_data_2(input_data_2),
    .hit_1(hit_1), .hit_2(hit_2),
    .read_data_1(read_data_1),
    .read_data_2(read_data_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d, required %0d",
               nm, act, exp);
    end
  endtask

  // model state: phase 0 idle, 1 active, 2 done
  // step 0 = op boundary, 1 = tag compare, 2 = fill/write
  logic [7:0] m_mem [256];
  logic [7:0] m_prog [2][SL];
  int         m_cnt [2], ph [2], stp [2], k [2];
  bit         m_v [2][8];
  int         m_tag [2][8];
  logic [7:0] m_dat [2][8];
  logic       e_hit [2];
  logic [7:0] e_rd [2];
  bit         wc [2], mw [2];
  logic [7:0] mw_a [2], mw_d [2];
  logic       mwr, mst;
  logic [7:0] mra, mwa, mwd, ma, mdi;
  int         li, o;

  task automatic mreset();
    for (int a = 0; a < 256; a++) m_mem[a] = 8'(a);
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; ph[c] = 0; stp[c] = 0; k[c] = 0;
      e_hit[c] = 1'b0; e_rd[c] = 8'd0;
      for (int s = 0; s < SL; s++) m_prog[c][s] = 8'd0;
      for (int l = 0; l < 8; l++) begin
        m_v[c][l] = 1'b0; m_tag[c][l] = 0; m_dat[c][l] = 0;
      end
    end
  endtask

  task automatic put(input int c, input logic [7:0] a,
                     input logic [7:0] d);
    m_v[c][a % 8]   = 1'b1;
    m_tag[c][a % 8] = a / 8;
    m_dat[c][a % 8] = d;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) mreset();
    else begin
      for (int c = 0; c < 2; c++) begin
        wc[c] = ph[c] == 1 && stp[c] == 2
             && m_prog[c][k[c]][0];
        mw[c] = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        e_hit[c] = 1'b0;
        mst = (c == 0) ? store1 : store2;
        mdi = (c == 0) ? input_data_1 : input_data_2;
        if (ph[c] == 0) begin
          if (mst) begin
            if (m_cnt[c] < SL) begin
              m_prog[c][m_cnt[c]] = mdi;
              m_cnt[c]++;
            end
          end else if (start) begin
            ph[c] = 1; stp[c] = 0; k[c] = 0;
          end
        end else if (ph[c] == 1) begin
          if (stp[c] == 0) begin
            if (k[c] == N) ph[c] = 2;
            else stp[c] = 1;
          end else begin
            mwr = m_prog[c][k[c]][0];
            mra = m_prog[c][N + k[c]];
            mwa = m_prog[c][2*N + k[c]];
            mwd = m_prog[c][3*N + k[c]];
            ma  = mwr ? mwa : mra;
            li  = ma % 8;
            if (stp[c] == 1) begin
              e_hit[c] = m_v[c][li] && m_tag[c][li] == ma / 8;
              if (!mwr && e_hit[c]) begin
                e_rd[c] = m_dat[c][li];
                k[c]++; stp[c] = 0;
              end else stp[c] = 2;
            end else if (!mwr) begin
              e_rd[c] = m_mem[mra];
              put(c, mra, m_mem[mra]);
              k[c]++; stp[c] = 0;
            end else if (!(c == 1 && wc[0])) begin
              put(c, mwa, mwd);
              mw[c] = 1'b1; mw_a[c] = mwa; mw_d[c] = mwd;
              k[c]++; stp[c] = 0;
            end
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (mw[c]) begin
          m_mem[mw_a[c]] = mw_d[c];
          o = 1 - c;
          li = mw_a[c] % 8;
          if (SNOOP && m_v[o][li]
              && m_tag[o][li] == mw_a[c] / 8)
            m_v[o][li] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      chk("hit_1", hit_1, e_hit[0]);
      chk("hit_2", hit_2, e_hit[1]);
      chk("read_data_1", read_data_1, e_rd[0]);
      chk("read_data_2", read_data_2, e_rd[1]);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1; start = 1'b0;
    store1 = 1'b0; store2 = 1'b0;
    #1;
    chk("rst_hit_1", hit_1, 0);
    chk("rst_hit_2", hit_2, 0);
    chk("rst_rd_1", read_data_1, 0);
    chk("rst_rd_2", read_data_2, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_go(input int n1, input int n2,
                         input bit st);
    for (int i = 0; i < n1 || i < n2; i++) begin
      @(negedge clk);
      start = st;
      store1 = (i < n1); store2 = (i < n2);
      input_data_1 = w1[i]; input_data_2 = w2[i];
    end
    @(negedge clk);
    store1 = 1'b0; store2 = 1'b0; start = 1'b1;
  endtask

  task automatic clr_w();
    for (int i = 0; i < 10; i++) begin
      w1[i] = 8'd0; w2[i] = 8'd0;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    store1 = 1'b0; store2 = 1'b0;
    input_data_1 = 8'd0; input_data_2 = 8'd0;
    @(negedge clk);
    do_reset();
    cmp_on = 1'b1;
    edges(3);

    // two read misses on ch1, empty program on ch2
    clr_w();
    w1 = '{0, 0, 12, 5, 23, 55, 1, 2, 0, 0};
    load_go(8, 0, 1'b0);
    edges(4);
    chk("t2_rd1_op0", read_data_1, 12);
    chk("t2_hit1_op0", hit_1, 0);
    edges(2);
    chk("t2_hit2_empty", hit_2, 1);
    edges(1);
    chk("t2_rd1_op1", read_data_1, 5);
    start = 1'b0;
    edges(4);
    chk("t2_done_hold", read_data_1, 5);

    // write miss then read hit, extra words must be dropped
    do_reset();
    clr_w();
    w1 = '{1, 0, 0, 23, 23, 0, 1, 0, 255, 255};
    load_go(10, 0, 1'b0);
    edges(6);
    chk("t3_hit1", hit_1, 1);
    chk("t3_rd1", read_data_1, 1);
    edges(1);
    chk("t3_hit1_pulse", hit_1, 0);

    // concurrent writes to the same addresses
    do_reset();
    clr_w();
    w1 = '{1, 1, 0, 0, 79, 234, 3, 4, 0, 0};
    w2 = '{1, 1, 0, 0, 79, 234, 5, 6, 0, 0};
    load_go(8, 8, 1'b0);
    edges(12);
    chk("t4_mem79", dut.mem[79], 5);
    chk("t4_mem234", dut.mem[234], 6);
    chk("t4_model79", m_mem[79], 5);
    chk("t4_model234", m_mem[234], 6);

    // write conflict shifts ch2 by one cycle; start held during load
    do_reset();
    clr_w();
    w1 = '{1, 0, 0, 50, 50, 0, 7, 0, 0, 0};
    w2 = '{1, 0, 0, 60, 60, 0, 8, 0, 0, 0};
    load_go(8, 8, 1'b1);
    edges(6);
    chk("t5_hit1", hit_1, 1);
    chk("t5_hit2_late", hit_2, 0);
    chk("t5_rd1", read_data_1, 7);
    edges(1);
    chk("t5_hit2", hit_2, 1);
    chk("t5_rd2", read_data_2, 8);

    // ch1 writes 40 on the edge ch2 fills 40
    do_reset();
    clr_w();
    w1 = '{1, 0, 0, 0, 40, 0, 9, 0, 0, 0};
    w2 = '{0, 0, 40, 40, 0, 0, 0, 0, 0, 0};
    load_go(8, 8, 1'b0);
    edges(6);
    chk("t6_hit2", hit_2, SNOOP ? 0 : 1);
    edges(2);
    chk("t6_rd2", read_data_2, SNOOP ? 9 : 40);

    // reset in the middle of a run
    do_reset();
    clr_w();
    w1 = '{0, 0, 12, 5, 23, 55, 1, 2, 0, 0};
    load_go(8, 0, 1'b0);
    edges(4);
    chk("t7_pre_rd1", read_data_1, 12);
    edges(2);
    chk("t7_pre_hit2", hit_2, 1);
    do_reset();
    edges(3);
    load_go(8, 0, 1'b0);
    edges(3);
    chk("t7_cache_cleared", hit_1, 0);
    edges(1);
    chk("t7_rd1_refill", read_data_1, 12);
    edges(6);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
